// File: rtl/arb_pkg.sv
// Shared types and mode encodings for the resource arbiter.
package arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    localparam int ARB_MODE_FIXED = 0;
    localparam int ARB_MODE_RR    = 1;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection: rotate the candidates so the search start
// sits at bit 0, priority-encode the lowest set bit, then undo the rotation.
module arb_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         mask,
    input  logic [$clog2(N)-1:0] start,
    output logic                 valid,
    output logic [$clog2(N)-1:0] idx
);

    localparam int            IW  = $clog2(N);
    localparam logic [IW:0]   N_W = (IW+1)'(N);

    logic [N-1:0]   cand_s;
    logic [2*N-1:0] dbl_s;
    logic [N-1:0]   rot_s;
    logic [IW-1:0]  enc_s;
    logic [IW:0]    sum_s;
    logic [IW:0]    wrap_s;

    assign cand_s = req & mask;
    assign dbl_s  = {cand_s, cand_s} >> start;
    assign rot_s  = dbl_s[N-1:0];

    // Lowest set bit of the rotated vector; scanning downward lets the lowest win.
    always_comb begin
        enc_s = {IW{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            enc_s = rot_s[i] ? IW'(i) : enc_s;
        end
    end

    // N need not be a power of two, so the unrotate wraps explicitly.
    assign sum_s  = {1'b0, start} + {1'b0, enc_s};
    assign wrap_s = (sum_s >= N_W) ? (sum_s - N_W) : sum_s;
    assign idx    = wrap_s[IW-1:0];
    assign valid  = |cand_s;

endmodule

// File: rtl/rr_arbiter.sv
// N-way hold-until-release arbiter, fixed priority or round robin.
// Define ARB_HOLD_TIMEOUT_EN to build the MAX_HOLD preemption counter.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MODE     = 1,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         r,
    output logic [N-1:0]         g,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_id
);

    localparam int IW = $clog2(N);

    arb_state_e    state_r, state_s;
    logic [IW-1:0] holder_r, holder_s;
    logic [IW-1:0] rr_ptr_r, rr_ptr_s;
    logic [IW-1:0] start_s;
    logic [IW-1:0] pick_idx_s;
    logic          pick_valid_s;
    logic [N-1:0]  mask_s;
    logic          preempt_s;
    logic [N-1:0]  g_r, g_s;
    logic          valid_r;

    // Search start: just past the last winner in round robin, index 0 otherwise.
    always_comb begin
        if (MODE == ARB_MODE_RR) begin
            start_s = (rr_ptr_r == IW'(N - 1)) ? {IW{1'b0}} : (rr_ptr_r + IW'(1));
        end else begin
            start_s = {IW{1'b0}};
        end
    end

`ifdef ARB_HOLD_TIMEOUT_EN
    localparam int             HW        = $clog2(MAX_HOLD);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(MAX_HOLD - 1);

    logic [HW-1:0] hold_cnt_r, hold_cnt_s;

    // g_r is the holder's one-hot while granted, so it doubles as the holder mask.
    assign preempt_s = (state_r == ARB_GRANT) && (hold_cnt_r == HOLD_LAST)
                     && (|(r & g_r)) && (|(r & ~g_r));
    assign mask_s    = preempt_s ? ~g_r : {N{1'b1}};

    // Consecutive-hold counter; any change of holder or idling restarts it.
    always_comb begin
        if ((state_r == ARB_GRANT) && r[holder_r] && !preempt_s) begin
            hold_cnt_s = (hold_cnt_r == HOLD_LAST) ? hold_cnt_r : (hold_cnt_r + HW'(1));
        end else begin
            hold_cnt_s = {HW{1'b0}};
        end
    end

    // Hold counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt_r <= {HW{1'b0}};
        end else begin
            hold_cnt_r <= hold_cnt_s;
        end
    end
`else
    assign preempt_s = 1'b0;
    assign mask_s    = {N{1'b1}};
`endif

    arb_pick #(.N(N)) u_pick (
        .req   (r),
        .mask  (mask_s),
        .start (start_s),
        .valid (pick_valid_s),
        .idx   (pick_idx_s)
    );

    // Next state, holder and pointer; grant outputs derived from the next holder.
    always_comb begin
        state_s  = state_r;
        holder_s = holder_r;
        rr_ptr_s = rr_ptr_r;
        case (state_r)
            ARB_IDLE: begin
                if (pick_valid_s) begin
                    state_s  = ARB_GRANT;
                    holder_s = pick_idx_s;
                    rr_ptr_s = pick_idx_s;
                end else begin
                    state_s  = ARB_IDLE;
                end
            end
            ARB_GRANT: begin
                if (preempt_s) begin
                    holder_s = pick_idx_s;
                    rr_ptr_s = pick_idx_s;
                end else if (r[holder_r]) begin
                    state_s  = ARB_GRANT;
                end else if (pick_valid_s) begin
                    holder_s = pick_idx_s;
                    rr_ptr_s = pick_idx_s;
                end else begin
                    state_s  = ARB_IDLE;
                    holder_s = {IW{1'b0}};
                end
            end
            default: begin
                state_s  = ARB_IDLE;
                holder_s = {IW{1'b0}};
            end
        endcase

        if (state_s == ARB_GRANT) begin
            g_s = {{(N-1){1'b0}}, 1'b1} << holder_s;
        end else begin
            g_s = {N{1'b0}};
        end
    end

    // State, holder, pointer and registered grant outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ARB_IDLE;
            holder_r <= {IW{1'b0}};
            rr_ptr_r <= IW'(N - 1);
            g_r      <= {N{1'b0}};
            valid_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            holder_r <= holder_s;
            rr_ptr_r <= rr_ptr_s;
            g_r      <= g_s;
            valid_r  <= (state_s == ARB_GRANT);
        end
    end

    assign g           = g_r;
    assign grant_valid = valid_r;
    assign grant_id    = holder_r;

endmodule
